instr_mem_sync: RTL and testbench
=================================

Name: instr_mem_sync

Overview:
- Parametrised, synchronous successor to the combinational 4-bit/8-bit instruction ROM.
- Registered one-cycle read with request/valid handshake.
- Writable program-load port, so the CPU's instruction store is filled at run time.
- Hardware clear sweep after reset fills every word with a NOP.
- Sits between the program counter (fetch side) and the debug/loader (program side).

Parameters:
- ADDR_W, 4, address width; DEPTH is fixed at 2**ADDR_W, so every address is valid.
- DATA_W, 8, instruction word width.
- NOP_WORD, {DATA_W{1'b0}}, value written to every word by the clear sweep.

Ports:
- clk  in  1  system clock, rising edge.
- n_reset  in  1  asynchronous active-low reset.
- fetch_req  in  1  fetch request from the PC stage.
- fetch_addr  in  ADDR_W  fetch address, sampled when fetch_req && fetch_ready.
- fetch_ready  out  1  fetch accepted this cycle (combinational).
- fetch_valid  out  1  fetch_data valid, one-cycle pulse per accepted fetch.
- fetch_data  out  DATA_W  fetched instruction word.
- fetch_perr  out  1  parity error on the fetched word (optional feature; else 0).
- prog_en  in  1  loader requests ownership of the memory.
- prog_we  in  1  write strobe, honoured only in PROG.
- prog_addr  in  ADDR_W  write address.
- prog_data  in  DATA_W  write data.
- busy  out  1  high in CLEAR or PROG.

Behaviour:
- Reset (n_reset low, asynchronous):
  - fetch_valid=0, fetch_data=0, fetch_perr=0, clear counter=0, state=CLEAR.
  - Array contents are not reset directly; the CLEAR sweep overwrites them.
- States are CLEAR, IDLE and PROG.
- CLEAR:
  - Each cycle writes NOP_WORD to address clr_cnt, then clr_cnt increments.
  - When clr_cnt==DEPTH-1 is written, the next state is IDLE and clr_cnt wraps to 0.
  - Takes exactly DEPTH cycles. fetch_ready=0 and busy=1 throughout.
  - prog_en is ignored until CLEAR completes.
- IDLE:
  - fetch_ready = (state==IDLE) && !prog_en.
  - Accepted fetch at edge N: fetch_valid=1 and fetch_data=mem[fetch_addr] after edge N; valid for exactly one cycle unless another fetch is accepted.
  - Back-to-back fetches give a valid pulse every cycle, at 1-cycle latency.
  - fetch_data holds its last value when fetch_valid=0.
  - prog_en=1 means next state is PROG. prog_en wins over a simultaneous fetch_req: the fetch is not accepted.
- PROG:
  - busy=1, fetch_ready=0, fetch_valid=0.
  - On each edge with prog_we=1, mem[prog_addr] <= prog_data.
  - prog_en=0 means next state is IDLE. prog_we in the same cycle as prog_en falling is still honoured.
- A fetch accepted in the last IDLE cycle before PROG still produces its valid pulse, with the pre-write data.
- A write in PROG followed by a fetch of the same address in IDLE returns the new data.
- Reset mid-CLEAR restarts the sweep from 0. Reset mid-PROG aborts the load; the sweep then overwrites all contents.
- No read-during-write hazard: reads and writes never share a cycle.

Optional Feature:
- Macro INSTR_MEM_PARITY_EN.
- With the macro defined:
  - Each word stores one extra even-parity bit (^data), computed on CLEAR and PROG writes.
  - On each fetch, fetch_perr = stored parity ^ (^read data), registered alongside fetch_data.
  - fetch_perr is valid only while fetch_valid=1.
- Without the macro: no extra storage, and fetch_perr is tied to 0.

Decomposition:
- Package instr_mem_pkg holds:
  - State enum with encoding CLEAR=2'd0, IDLE=2'd1, PROG=2'd2.
  - Default widths (ADDR_W=4, DATA_W=8).
  - NOP opcode constant.
- One sub-module, instr_mem_array: a 1-write/1-read registered storage array of DEPTH x (DATA_W + optional parity).
- The FSM, clear counter and port muxing live in the top level.

Test Plan:
- Reset release -> busy=1 and fetch_ready=0 for exactly 16 cycles (ADDR_W=4); then a fetch of addresses 0..15 returns 8'h00 each, with valid one cycle after request.
- Load via PROG of mem[i]=8'hA0+i for i=0..15, then 16 back-to-back fetches -> fetch_valid high for 16 consecutive cycles, data 8'hA0..8'hAF in order.
- prog_en and fetch_req asserted in the same IDLE cycle -> fetch_ready=0, no valid pulse, state PROG next cycle.
- Assert n_reset low mid-PROG after writing mem[3]=8'h5C -> outputs zero immediately; after the 16-cycle sweep, fetch of address 3 returns 8'h00.
- ADDR_W=6, DATA_W=16: write mem[63]=16'hBEEF -> fetch of 63 returns 16'hBEEF; clear sweep lasts 64 cycles.
- INIT and PARITY_EN: force-flip one bit of stored word 5 -> fetch of 5 gives fetch_perr=1; other addresses give 0.

Source files
------------

// File: rtl/instr_mem_pkg.sv
// Shared types and defaults for the synchronous instruction memory.
package instr_mem_pkg;

  typedef enum logic [1:0] {
    StClear = 2'd0,
    StIdle  = 2'd1,
    StProg  = 2'd2
  } instr_mem_state_e;

  localparam int unsigned DefAddrW = 4;
  localparam int unsigned DefDataW = 8;

  localparam logic [DefDataW-1:0] NopOpcode = 8'h00;

  // Even parity over a word of up to 64 bits; unused upper bits must be zero.
  function automatic logic even_parity(input logic [63:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/instr_mem_array.sv
// One-write / one-read storage array with a registered, resettable read port.
module instr_mem_array #(
  parameter int unsigned AddrW = 4,
  parameter int unsigned Width = 8
) (
  input  logic             clk,
  input  logic             n_reset,
  input  logic             we,
  input  logic [AddrW-1:0] waddr,
  input  logic [Width-1:0] wdata,
  input  logic             re,
  input  logic [AddrW-1:0] raddr,
  output logic [Width-1:0] rdata
);

  localparam int unsigned Depth = 2 ** AddrW;

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] rdata_q;

  // Storage carries no reset; the clear sweep initialises it.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      rdata_q <= '0;
    end else if (re) begin
      rdata_q <= mem_q[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/instr_mem_sync.sv
// Synchronous instruction memory: clear sweep, fetch port and program-load port.
// Define INSTR_MEM_PARITY_EN to store and check one even-parity bit per word.
module instr_mem_sync
  import instr_mem_pkg::*;
#(
  parameter int unsigned       ADDR_W   = DefAddrW,
  parameter int unsigned       DATA_W   = DefDataW,
  parameter logic [DATA_W-1:0] NOP_WORD = {DATA_W{1'b0}}
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_ready,
  output logic              fetch_valid,
  output logic [DATA_W-1:0] fetch_data,
  output logic              fetch_perr,
  input  logic              prog_en,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  output logic              busy
);

`ifdef INSTR_MEM_PARITY_EN
  localparam int unsigned WordW = DATA_W + 1;
`else
  localparam int unsigned WordW = DATA_W;
`endif

  instr_mem_state_e  state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic              fetch_valid_q;
  logic              fetch_accept;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic [WordW-1:0]  mem_wword;
  logic [WordW-1:0]  mem_rword;

  always_comb begin
    state_d     = state_q;
    clr_cnt_d   = clr_cnt_q;
    fetch_ready = 1'b0;
    busy        = 1'b0;
    mem_we      = 1'b0;
    mem_waddr   = prog_addr;
    mem_wdata   = prog_data;
    unique case (state_q)
      StClear: begin
        busy      = 1'b1;
        mem_we    = 1'b1;
        mem_waddr = clr_cnt_q;
        mem_wdata = NOP_WORD;
        clr_cnt_d = clr_cnt_q + ADDR_W'(1);
        if (clr_cnt_q == {ADDR_W{1'b1}}) begin
          state_d = StIdle;
        end
      end
      StIdle: begin
        // A loader request takes priority over a fetch in the same cycle.
        fetch_ready = !prog_en;
        if (prog_en) begin
          state_d = StProg;
        end
      end
      StProg: begin
        busy   = 1'b1;
        mem_we = prog_we;
        if (!prog_en) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d   = StClear;
        clr_cnt_d = '0;
      end
    endcase
  end

  assign fetch_accept = fetch_req && fetch_ready;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q       <= StClear;
      clr_cnt_q     <= '0;
      fetch_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      clr_cnt_q     <= clr_cnt_d;
      fetch_valid_q <= fetch_accept;
    end
  end

`ifdef INSTR_MEM_PARITY_EN
  assign mem_wword  = {^mem_wdata, mem_wdata};
  // Read register resets to zero, so the check is quiet out of reset too.
  assign fetch_perr = fetch_valid_q & (mem_rword[DATA_W] ^ (^mem_rword[DATA_W-1:0]));
`else
  assign mem_wword  = mem_wdata;
  assign fetch_perr = 1'b0;
`endif

  instr_mem_array #(
    .AddrW (ADDR_W),
    .Width (WordW)
  ) u_array (
    .clk     (clk),
    .n_reset (n_reset),
    .we      (mem_we),
    .waddr   (mem_waddr),
    .wdata   (mem_wword),
    .re      (fetch_accept),
    .raddr   (fetch_addr),
    .rdata   (mem_rword)
  );

  assign fetch_valid = fetch_valid_q;
  assign fetch_data  = mem_rword[DATA_W-1:0];

endmodule

// File: tb/tb_instr_mem_sync.sv
// Directed bench for instr_mem_sync: default 4x8 instance plus a 6x16 instance.
module tb_instr_mem_sync;

  logic       clk = 1'b0;
  logic       n_reset;
  logic       fetch_req;
  logic [3:0] fetch_addr;
  logic       fetch_ready, fetch_valid, fetch_perr, busy;
  logic [7:0] fetch_data;
  logic       prog_en, prog_we;
  logic [3:0] prog_addr;
  logic [7:0] prog_data;

  logic        w_n_reset;
  logic        w_fetch_req;
  logic [5:0]  w_fetch_addr;
  logic        w_fetch_ready, w_fetch_valid, w_fetch_perr, w_busy;
  logic [15:0] w_fetch_data;
  logic        w_prog_en, w_prog_we;
  logic [5:0]  w_prog_addr;
  logic [15:0] w_prog_data;

  int n_chk = 0;
  int n_bad = 0;
  int c1, c2;

  always #5 clk = ~clk;

  instr_mem_sync u_dut (
    .clk         (clk),
    .n_reset     (n_reset),
    .fetch_req   (fetch_req),
    .fetch_addr  (fetch_addr),
    .fetch_ready (fetch_ready),
    .fetch_valid (fetch_valid),
    .fetch_data  (fetch_data),
    .fetch_perr  (fetch_perr),
    .prog_en     (prog_en),
    .prog_we     (prog_we),
    .prog_addr   (prog_addr),
    .prog_data   (prog_data),
    .busy        (busy)
  );

  instr_mem_sync #(
    .ADDR_W (6),
    .DATA_W (16)
  ) u_dut_w (
    .clk         (clk),
    .n_reset     (w_n_reset),
    .fetch_req   (w_fetch_req),
    .fetch_addr  (w_fetch_addr),
    .fetch_ready (w_fetch_ready),
    .fetch_valid (w_fetch_valid),
    .fetch_data  (w_fetch_data),
    .fetch_perr  (w_fetch_perr),
    .prog_en     (w_prog_en),
    .prog_we     (w_prog_we),
    .prog_addr   (w_prog_addr),
    .prog_data   (w_prog_data),
    .busy        (w_busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one active edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch_one(input logic [3:0] addr, input logic [7:0] exp, input string tag);
    fetch_req  = 1'b1;
    fetch_addr = addr;
    chk({tag, "_rdy"}, 32'(fetch_ready), 32'd1);
    tick();
    fetch_req = 1'b0;
    chk({tag, "_vld"}, 32'(fetch_valid), 32'd1);
    chk({tag, "_dat"}, 32'(fetch_data), 32'(exp));
  endtask

  initial begin
    n_reset = 1'b0; fetch_req = 1'b0; fetch_addr = '0;
    prog_en = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
    w_n_reset = 1'b0; w_fetch_req = 1'b0; w_fetch_addr = '0;
    w_prog_en = 1'b0; w_prog_we = 1'b0; w_prog_addr = '0; w_prog_data = '0;

    #3;
    chk("rst_vld", 32'(fetch_valid), 32'd0);
    chk("rst_dat", 32'(fetch_data), 32'd0);
    chk("rst_perr", 32'(fetch_perr), 32'd0);
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_rdy", 32'(fetch_ready), 32'd0);
    chk("rst_w_dat", 32'(w_fetch_data), 32'd0);

    tick();
    tick();
    n_reset   = 1'b1;
    w_n_reset = 1'b1;

    // Sweep length: count edges until busy drops.
    c1 = 0;
    c2 = 0;
    for (int i = 1; i <= 80; i++) begin
      tick();
      if (!busy && c1 == 0) c1 = i;
      if (!w_busy && c2 == 0) c2 = i;
      if (i == 15) chk("clr_rdy_low", 32'(fetch_ready), 32'd0);
    end
    chk("clr_len", 32'(c1), 32'd16);
    chk("clr_len_w", 32'(c2), 32'd64);

    for (int a = 0; a < 16; a++) fetch_one(4'(a), 8'h00, "nop");
    tick();
    chk("nop_vld_drop", 32'(fetch_valid), 32'd0);

    // Program A0+i; last write coincides with prog_en falling.
    prog_en = 1'b1;
    tick();
    chk("prog_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 16; i++) begin
      prog_we   = 1'b1;
      prog_addr = 4'(i);
      prog_data = 8'hA0 + 8'(i);
      if (i == 15) prog_en = 1'b0;
      tick();
    end
    prog_we = 1'b0;
    chk("prog_exit", 32'(busy), 32'd0);

    for (int i = 0; i < 16; i++) begin
      fetch_req  = 1'b1;
      fetch_addr = 4'(i);
      tick();
      chk("b2b_vld", 32'(fetch_valid), 32'd1);
      chk("b2b_dat", 32'(fetch_data), 32'hA0 + 32'(i));
    end
    fetch_req = 1'b0;
    tick();
    chk("hold_vld", 32'(fetch_valid), 32'd0);
    chk("hold_dat", 32'(fetch_data), 32'hAF);

    // Loader beats a simultaneous fetch.
    fetch_req  = 1'b1;
    fetch_addr = 4'd2;
    prog_en    = 1'b1;
    #1;
    chk("conf_rdy", 32'(fetch_ready), 32'd0);
    tick();
    fetch_req = 1'b0;
    chk("conf_vld", 32'(fetch_valid), 32'd0);
    chk("conf_busy", 32'(busy), 32'd1);
    chk("conf_dat", 32'(fetch_data), 32'hAF);

    prog_we   = 1'b1;
    prog_addr = 4'd3;
    prog_data = 8'h5C;
    tick();
    prog_we = 1'b0;

    // Reset mid-PROG.
    #2;
    n_reset = 1'b0;
    #1;
    chk("mrst_dat", 32'(fetch_data), 32'd0);
    chk("mrst_vld", 32'(fetch_valid), 32'd0);
    chk("mrst_busy", 32'(busy), 32'd1);
    @(posedge clk);
    #1;
    prog_en = 1'b0;
    n_reset = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      tick();
      if (i == 15) chk("mrst_clr15", 32'(busy), 32'd1);
    end
    chk("mrst_clr16", 32'(busy), 32'd0);
    fetch_one(4'd3, 8'h00, "mrst_a3");
    fetch_one(4'd4, 8'h00, "mrst_a4");

    // Wide instance: top address round-trip.
    w_prog_en = 1'b1;
    tick();
    w_prog_we   = 1'b1;
    w_prog_addr = 6'd63;
    w_prog_data = 16'hBEEF;
    tick();
    w_prog_we = 1'b0;
    w_prog_en = 1'b0;
    tick();
    w_fetch_req  = 1'b1;
    w_fetch_addr = 6'd63;
    chk("w_rdy", 32'(w_fetch_ready), 32'd1);
    tick();
    w_fetch_req = 1'b0;
    chk("w_vld", 32'(w_fetch_valid), 32'd1);
    chk("w_dat", 32'(w_fetch_data), 32'hBEEF);
    chk("w_perr", 32'(w_fetch_perr), 32'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
